// File: rtl/hdmi_link_sequencer_if.sv
// ============================================================================
// hdmi_link_sequencer_if : control/status bundle of the HDMI link sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface hdmi_link_sequencer_if #(
  parameter int RETRY_W = 3
);
  logic               enable;
  logic               locked_des_a;
  logic               locked_ser_a;
  logic [2:0]         bond_vld_a;
  logic               mmcm_rst;
  logic               rx_arst;
  logic               tx_rst;
  logic               tx_pass;
  logic               link_up;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state;

  modport master (
    input  enable, locked_des_a, locked_ser_a, bond_vld_a,
    output mmcm_rst, rx_arst, tx_rst, tx_pass, link_up, fault, retry_cnt, state
  );

  modport slave (
    output enable, locked_des_a, locked_ser_a, bond_vld_a,
    input  mmcm_rst, rx_arst, tx_rst, tx_pass, link_up, fault, retry_cnt, state
  );
endinterface

`default_nettype wire

// File: rtl/hdmi_link_sequencer.sv
// ============================================================================
// hdmi_link_sequencer : HDMI pass-through bring-up / link-loss recovery FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module hdmi_link_sequencer #(
  parameter int RST_CYC     = 16,
  parameter int SETTLE_CYC  = 1024,
  parameter int LOCK_TO     = 2**20,
  parameter int BOND_TO     = 2**20,
  parameter int DROP_CYC    = 8,
  parameter int BACKOFF_CYC = 2**16,
  parameter int MAX_RETRY   = 7
) (
  input  logic                   clk,
  input  logic                   rst_raw_n,
  hdmi_link_sequencer_if.master  bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_retry_w = $clog2(MAX_RETRY + 1);
  localparam int c_tmr_w   = $clog2(max2(max2(LOCK_TO, BOND_TO), max2(BACKOFF_CYC, RST_CYC)) + 1);
  localparam int c_cons_w  = $clog2(max2(SETTLE_CYC, DROP_CYC) + 1);

  localparam logic [c_tmr_w-1:0]   c_rst_last     = c_tmr_w'(RST_CYC - 1);
  localparam logic [c_tmr_w-1:0]   c_lock_last    = c_tmr_w'(LOCK_TO - 1);
  localparam logic [c_tmr_w-1:0]   c_bond_last    = c_tmr_w'(BOND_TO - 1);
  localparam logic [c_tmr_w-1:0]   c_backoff_last = c_tmr_w'(BACKOFF_CYC - 1);
  localparam logic [c_cons_w-1:0]  c_settle_last  = c_cons_w'(SETTLE_CYC - 1);
  localparam logic [c_cons_w-1:0]  c_drop_last    = c_cons_w'(DROP_CYC - 1);
  localparam logic [c_retry_w-1:0] c_max_retry    = c_retry_w'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MMCM_RST  = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_RX_RST    = 3'd3,
    S_WAIT_BOND = 3'd4,
    S_TX_RST    = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_tmr_w-1:0]   r_timer;
  logic [c_cons_w-1:0]  r_cons;
  logic [c_retry_w-1:0] r_retry;
  logic [c_retry_w-1:0] w_retry_next;
  logic                 w_cond;
  logic                 r_des_s1, r_des_s2, r_ser_s1, r_ser_s2;
  logic [2:0]           r_bond_s1, r_bond_s2;
  logic                 r_mmcm_rst, r_rx_arst, r_tx_rst, r_run, r_fault;
  logic                 w_locks_ok, w_bond_ok;

  assign w_locks_ok = r_des_s2 & r_ser_s2;
  assign w_bond_ok  = &r_bond_s2;

  // w_cond is the per-state "consecutive cycles" qualifier feeding r_cons:
  // settle condition while waiting, bad-link condition while running.
  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_cond       = 1'b0;
    case (r_state)
      S_IDLE:      if (bus.enable) w_next = S_MMCM_RST;
      S_MMCM_RST:  if (r_timer >= c_rst_last) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        w_cond = w_locks_ok;
        if (r_timer >= c_lock_last)                      w_next = S_FAULT;
        else if (w_locks_ok && r_cons >= c_settle_last)  w_next = S_RX_RST;
      end
      S_RX_RST: begin
        if (!w_locks_ok)                 w_next = S_FAULT;
        else if (r_timer >= c_rst_last)  w_next = S_WAIT_BOND;
      end
      S_WAIT_BOND: begin
        w_cond = w_bond_ok;
        if (!w_locks_ok)                                w_next = S_FAULT;
        else if (r_timer >= c_bond_last)                w_next = S_FAULT;
        else if (w_bond_ok && r_cons >= c_settle_last)  w_next = S_TX_RST;
      end
      S_TX_RST: begin
        if (!w_locks_ok)                 w_next = S_FAULT;
        else if (r_timer >= c_rst_last)  w_next = S_RUN;
      end
      S_RUN: begin
        w_cond = !(w_locks_ok && w_bond_ok);
        if (w_cond && r_cons >= c_drop_last) w_next = S_FAULT;
      end
      S_FAULT: begin
        if (r_timer >= c_backoff_last && r_retry < c_max_retry) begin
          w_next       = S_MMCM_RST;
          w_retry_next = r_retry + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (!bus.enable) w_next = S_IDLE;
    if (w_next == S_IDLE) w_retry_next = '0;
  end

  always_ff @(posedge clk or negedge rst_raw_n) begin
    if (!rst_raw_n) begin
      r_des_s1   <= 1'b0;
      r_des_s2   <= 1'b0;
      r_ser_s1   <= 1'b0;
      r_ser_s2   <= 1'b0;
      r_bond_s1  <= 3'b000;
      r_bond_s2  <= 3'b000;
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_cons     <= '0;
      r_retry    <= '0;
      r_mmcm_rst <= 1'b1;
      r_rx_arst  <= 1'b1;
      r_tx_rst   <= 1'b1;
      r_run      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_des_s1   <= bus.locked_des_a;
      r_des_s2   <= r_des_s1;
      r_ser_s1   <= bus.locked_ser_a;
      r_ser_s2   <= r_ser_s1;
      r_bond_s1  <= bus.bond_vld_a;
      r_bond_s2  <= r_bond_s1;
      r_state    <= w_next;
      r_retry    <= w_retry_next;
      if (w_next != r_state) begin
        r_timer <= '0;
        r_cons  <= '0;
      end else begin
        if (r_timer != '1) r_timer <= r_timer + 1'b1;
        if (!w_cond)            r_cons <= '0;
        else if (r_cons != '1)  r_cons <= r_cons + 1'b1;
      end
      // Outputs decode the next state so they switch on the same edge as r_state.
      r_mmcm_rst <= (w_next == S_IDLE) || (w_next == S_MMCM_RST) || (w_next == S_FAULT);
      r_rx_arst  <= !((w_next == S_WAIT_BOND) || (w_next == S_TX_RST) || (w_next == S_RUN));
      r_tx_rst   <= (w_next != S_RUN);
      r_run      <= (w_next == S_RUN);
      r_fault    <= (w_next == S_FAULT);
    end
  end

  assign bus.mmcm_rst  = r_mmcm_rst;
  assign bus.rx_arst   = r_rx_arst;
  assign bus.tx_rst    = r_tx_rst;
  assign bus.tx_pass   = r_run;
  assign bus.link_up   = r_run;
  assign bus.fault     = r_fault;
  assign bus.retry_cnt = r_retry;
  assign bus.state     = r_state;

endmodule

`default_nettype wire
